// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand-forwarding selects and load-use stall.
// Keeps a shadow of the destination tags held by the EX, MEM and WB stages.
module fwd_hazard_unit #(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            en,
  input  logic            flush,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_regwr,
  input  logic [REGW-1:0] id_wsel,
  input  logic            id_memread,
  input  logic            id_lui,
  output logic [2:0]      forwarda,
  output logic [2:0]      forwardb,
  output logic            stall,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [2:0] SEL_RF  = 3'b000;
  localparam logic [2:0] SEL_ALU = 3'b001;
  localparam logic [2:0] SEL_WB  = 3'b010;
  localparam logic [2:0] SEL_UP  = 3'b011;

  typedef struct packed {
    logic [REGW-1:0] wsel;
    logic            regwr;
    logic            memread;
    logic            lui;
  } dst_t;

  typedef struct packed {
    logic [REGW-1:0] rs;
    logic [REGW-1:0] rt;
    dst_t            dst;
  } ex_t;

  ex_t             ex_q;
  ex_t             ex_d;
  dst_t            mem_q;
  logic [REGW-1:0] wb_wsel;
  logic            wb_regwr;
  logic            cnt_sat;

  // Youngest producer wins; a load sitting in MEM has no data yet and falls through.
  function automatic logic [2:0] fwd_sel(input logic [REGW-1:0] src,
                                         input dst_t            m,
                                         input logic [REGW-1:0] wbw,
                                         input logic            wbr);
    logic mem_hit;
    mem_hit = m.regwr && (m.wsel == src);
    if (src == '0)                  fwd_sel = SEL_RF;
    else if (mem_hit && m.lui)      fwd_sel = SEL_UP;
    else if (mem_hit && !m.memread) fwd_sel = SEL_ALU;
    else if (wbr && (wbw == src))   fwd_sel = SEL_WB;
    else                            fwd_sel = SEL_RF;
  endfunction

  always_comb begin
    stall = ex_q.dst.regwr && ex_q.dst.memread && (ex_q.dst.wsel != '0) &&
            ((ex_q.dst.wsel == id_rs) || (ex_q.dst.wsel == id_rt)) && !flush;

    ex_d = '0;
    if (!flush && !stall) begin
      ex_d.rs          = id_rs;
      ex_d.rt          = id_rt;
      ex_d.dst.wsel    = id_wsel;
      ex_d.dst.regwr   = id_regwr;
      ex_d.dst.memread = id_memread;
      ex_d.dst.lui     = id_lui;
    end

    forwarda = fwd_sel(ex_q.rs, mem_q, wb_wsel, wb_regwr);
    forwardb = fwd_sel(ex_q.rt, mem_q, wb_wsel, wb_regwr);
    cnt_sat  = &stall_cnt;
  end

  // WB only needs the destination and write flag to resolve the writeback path.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_wsel   <= '0;
      wb_regwr  <= 1'b0;
      stall_cnt <= '0;
    end else if (en) begin
      wb_wsel  <= mem_q.wsel;
      wb_regwr <= mem_q.regwr;
      mem_q    <= ex_q.dst;
      ex_q     <= ex_d;
      if (stall && !cnt_sat) stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scoreboard bench for the forwarding/stall unit.
// Counter width is shrunk so saturation is reachable in a short run.
module tb_fwd_hazard_unit;
  localparam int REGW = 5;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            en = 1'b1;
  logic            flush = 1'b0;
  logic [REGW-1:0] id_rs = '0;
  logic [REGW-1:0] id_rt = '0;
  logic            id_regwr = 1'b0;
  logic [REGW-1:0] id_wsel = '0;
  logic            id_memread = 1'b0;
  logic            id_lui = 1'b0;
  logic [2:0]      forwarda;
  logic [2:0]      forwardb;
  logic            stall;
  logic [CNTW-1:0] stall_cnt;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    string           name;
    logic [REGW-1:0] rs, rt, wsel;
    logic            regwr, memread, lui, flush, en;
    logic [2:0]      fa, fb;
    logic            st;
    logic [CNTW-1:0] cnt;
  } step_t;

  typedef struct {
    string           name;
    logic [2:0]      fa, fb;
    logic            st;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  fwd_hazard_unit #(.REGW(REGW), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_regwr(id_regwr), .id_wsel(id_wsel),
    .id_memread(id_memread), .id_lui(id_lui),
    .forwarda(forwarda), .forwardb(forwardb), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  // A consumer must never reach EX while its load is still in MEM.
  always @(negedge CLK) begin
    if (!RST) begin
      assert (!(dut.mem_q.regwr && dut.mem_q.memread &&
                ((dut.ex_q.rs != 0 && dut.ex_q.rs == dut.mem_q.wsel) ||
                 (dut.ex_q.rt != 0 && dut.ex_q.rt == dut.mem_q.wsel))))
        else $error("load in MEM feeds the instruction in EX");
    end
  end

  function automatic step_t mk(string nm, int rs, int rt, int wsel, bit regwr, bit mr,
                               bit lui, bit fl, bit e, int fa, int fb, bit st, int cnt);
    step_t s;
    s.name = nm;  s.rs = REGW'(rs);  s.rt = REGW'(rt);  s.wsel = REGW'(wsel);
    s.regwr = regwr;  s.memread = mr;  s.lui = lui;  s.flush = fl;  s.en = e;
    s.fa = 3'(fa);  s.fb = 3'(fb);  s.st = st;  s.cnt = CNTW'(cnt);
    return s;
  endfunction

  task automatic drive(input step_t s);
    exp_t x;
    id_rs = s.rs;  id_rt = s.rt;  id_wsel = s.wsel;  id_regwr = s.regwr;
    id_memread = s.memread;  id_lui = s.lui;  flush = s.flush;  en = s.en;
    x.name = s.name;  x.fa = s.fa;  x.fb = s.fb;  x.st = s.st;  x.cnt = s.cnt;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    id_rs = 5'd8;  id_rt = 5'd8;  id_wsel = 5'd8;  id_regwr = 1'b1;  id_memread = 1'b1;
    @(posedge CLK); #1;
    n_chk++; if (forwarda !== 3'b000) $display("FAIL reset_fa got=%b exp=000", forwarda); else n_pass++;
    n_chk++; if (forwardb !== 3'b000) $display("FAIL reset_fb got=%b exp=000", forwardb); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else n_pass++;
    n_chk++; if (stall_cnt !== '0) $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); else n_pass++;
    RST = 1'b0;
  endtask

  task automatic test_forwarding();
    step_t q[$];
    exp_t  e;
    q.push_back(mk("fwd_start",     1,  2,  3, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(mk("b2b_prod_ex",   3,  3,  4, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(mk("b2b_fwd",       0,  0,  5, 1, 0, 0, 0, 1, 1, 1, 0, 0));
    q.push_back(mk("dist2_indep",   1,  1,  6, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(mk("dist2_cons_id", 5,  9, 10, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(mk("dist2_fwd",     0,  0,  7, 1, 0, 1, 0, 1, 2, 0, 0, 0));
    q.push_back(mk("lui_prod_ex",  12,  7, 13, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(mk("lui_fwd",       0,  0,  2, 1, 0, 0, 0, 1, 0, 3, 0, 0));
    q.push_back(mk("w2a_ex",        1,  1,  2, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(mk("w2b_ex",        2, 14, 15, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(mk("youngest_fwd",  0,  0,  0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
    q.push_back(mk("p0_ex",         0,  0, 16, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(mk("r0_no_fwd",     0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i]);
      #1;
      e = sb.pop_front();
      n_chk++; if (forwarda !== e.fa) $display("FAIL %s forwarda got=%b exp=%b", e.name, forwarda, e.fa); else n_pass++;
      n_chk++; if (forwardb !== e.fb) $display("FAIL %s forwardb got=%b exp=%b", e.name, forwardb, e.fb); else n_pass++;
      n_chk++; if (stall !== e.st) $display("FAIL %s stall got=%b exp=%b", e.name, stall, e.st); else n_pass++;
      n_chk++; if (stall_cnt !== e.cnt) $display("FAIL %s stall_cnt got=%0d exp=%0d", e.name, stall_cnt, e.cnt); else n_pass++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_load_use();
    step_t q[$];
    exp_t  e;
    q.push_back(mk("lu_lw",        1, 0, 8, 1, 1, 0, 0, 1, 0, 0, 0, 1 - 1));
    q.push_back(mk("lu_stall",     8, 3, 9, 1, 0, 0, 0, 1, 0, 0, 1, 0));
    q.push_back(mk("lu_bubble",    8, 3, 9, 1, 0, 0, 0, 1, 0, 0, 0, 1));
    q.push_back(mk("lu_wb_fwd",    0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1));
    q.push_back(mk("lu2_lw",       0, 0, 8, 1, 1, 0, 0, 1, 0, 0, 0, 1));
    q.push_back(mk("lu2_hold_a",   0, 8, 9, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    q.push_back(mk("lu2_hold_b",   0, 8, 9, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    q.push_back(mk("lu2_stall",    0, 8, 9, 1, 0, 0, 0, 1, 0, 0, 1, 1));
    q.push_back(mk("lu2_bubble",   0, 8, 9, 1, 0, 0, 0, 1, 0, 0, 0, 2));
    q.push_back(mk("lu2_wb_fwd",   0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 2));
    foreach (q[i]) begin
      drive(q[i]);
      #1;
      e = sb.pop_front();
      n_chk++; if (forwarda !== e.fa) $display("FAIL %s forwarda got=%b exp=%b", e.name, forwarda, e.fa); else n_pass++;
      n_chk++; if (forwardb !== e.fb) $display("FAIL %s forwardb got=%b exp=%b", e.name, forwardb, e.fb); else n_pass++;
      n_chk++; if (stall !== e.st) $display("FAIL %s stall got=%b exp=%b", e.name, stall, e.st); else n_pass++;
      n_chk++; if (stall_cnt !== e.cnt) $display("FAIL %s stall_cnt got=%0d exp=%0d", e.name, stall_cnt, e.cnt); else n_pass++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_flush();
    step_t q[$];
    exp_t  e;
    q.push_back(mk("fl_lw",         0, 0, 8, 1, 1, 0, 0, 1, 0, 0, 0, 2));
    q.push_back(mk("fl_hazard",     8, 8, 9, 1, 0, 0, 1, 1, 0, 0, 0, 2));
    q.push_back(mk("fl_bubble",     8, 8, 9, 1, 0, 0, 0, 1, 0, 0, 0, 2));
    q.push_back(mk("fl_cons_wb",    0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 2));
    q.push_back(mk("fl_squash",     0, 0, 4, 1, 0, 0, 1, 1, 0, 0, 0, 2));
    q.push_back(mk("fl_sq_bubble",  4, 9, 10, 1, 0, 0, 0, 1, 0, 0, 0, 2));
    q.push_back(mk("fl_sq_no_fwd",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2));
    foreach (q[i]) begin
      drive(q[i]);
      #1;
      e = sb.pop_front();
      n_chk++; if (forwarda !== e.fa) $display("FAIL %s forwarda got=%b exp=%b", e.name, forwarda, e.fa); else n_pass++;
      n_chk++; if (forwardb !== e.fb) $display("FAIL %s forwardb got=%b exp=%b", e.name, forwardb, e.fb); else n_pass++;
      n_chk++; if (stall !== e.st) $display("FAIL %s stall got=%b exp=%b", e.name, stall, e.st); else n_pass++;
      n_chk++; if (stall_cnt !== e.cnt) $display("FAIL %s stall_cnt got=%0d exp=%0d", e.name, stall_cnt, e.cnt); else n_pass++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_saturation();
    step_t q[$];
    exp_t  e;
    for (int i = 0; i < 15; i++) begin
      int c;
      c = (2 + i > CMAX) ? CMAX : 2 + i;
      q.push_back(mk("sat_lw",    0, 0, 8, 1, 1, 0, 0, 1, 0, 0, 0, c));
      q.push_back(mk("sat_stall", 8, 0, 9, 1, 0, 0, 0, 1, 0, 0, 1, c));
    end
    q.push_back(mk("sat_final", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, CMAX));
    foreach (q[i]) begin
      drive(q[i]);
      #1;
      e = sb.pop_front();
      n_chk++; if (forwarda !== e.fa) $display("FAIL %s forwarda got=%b exp=%b", e.name, forwarda, e.fa); else n_pass++;
      n_chk++; if (forwardb !== e.fb) $display("FAIL %s forwardb got=%b exp=%b", e.name, forwardb, e.fb); else n_pass++;
      n_chk++; if (stall !== e.st) $display("FAIL %s stall got=%b exp=%b", e.name, stall, e.st); else n_pass++;
      n_chk++; if (stall_cnt !== e.cnt) $display("FAIL %s stall_cnt got=%0d exp=%0d", e.name, stall_cnt, e.cnt); else n_pass++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_midreset();
    step_t q[$];
    exp_t  e;
    q.push_back(mk("mr_alu", 0, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0, CMAX));
    q.push_back(mk("mr_lw",  3, 3, 6, 1, 1, 0, 0, 1, 0, 0, 0, CMAX));
    foreach (q[i]) begin
      drive(q[i]);
      #1;
      e = sb.pop_front();
      n_chk++; if (forwarda !== e.fa) $display("FAIL %s forwarda got=%b exp=%b", e.name, forwarda, e.fa); else n_pass++;
      n_chk++; if (forwardb !== e.fb) $display("FAIL %s forwardb got=%b exp=%b", e.name, forwardb, e.fb); else n_pass++;
      n_chk++; if (stall !== e.st) $display("FAIL %s stall got=%b exp=%b", e.name, stall, e.st); else n_pass++;
      n_chk++; if (stall_cnt !== e.cnt) $display("FAIL %s stall_cnt got=%0d exp=%0d", e.name, stall_cnt, e.cnt); else n_pass++;
      @(posedge CLK); #1;
    end
    id_rs = 5'd6;  id_rt = 5'd6;  id_wsel = 5'd7;  id_regwr = 1'b1;  id_memread = 1'b0;
    id_lui = 1'b0;  flush = 1'b0;  en = 1'b1;
    #1;
    n_chk++; if (forwarda !== 3'b001) $display("FAIL mr_inflight_fa got=%b exp=001", forwarda); else n_pass++;
    n_chk++; if (forwardb !== 3'b001) $display("FAIL mr_inflight_fb got=%b exp=001", forwardb); else n_pass++;
    n_chk++; if (stall !== 1'b1) $display("FAIL mr_inflight_stall got=%b exp=1", stall); else n_pass++;
    RST = 1'b1;
    #1;
    n_chk++; if (forwarda !== 3'b000) $display("FAIL mr_async_fa got=%b exp=000", forwarda); else n_pass++;
    n_chk++; if (forwardb !== 3'b000) $display("FAIL mr_async_fb got=%b exp=000", forwardb); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL mr_async_stall got=%b exp=0", stall); else n_pass++;
    n_chk++; if (stall_cnt !== '0) $display("FAIL mr_async_cnt got=%0d exp=0", stall_cnt); else n_pass++;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    n_chk++; if (forwarda !== 3'b000) $display("FAIL mr_after_fa got=%b exp=000", forwarda); else n_pass++;
    n_chk++; if (forwardb !== 3'b000) $display("FAIL mr_after_fb got=%b exp=000", forwardb); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL mr_after_stall got=%b exp=0", stall); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_flush();
    test_saturation();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
